// File: rtl/acc_sequencer.sv
// rtl/acc_sequencer.sv - instruction sequencer and accumulator owner in front of the ALU
module acc_sequencer #(
    parameter int          CNT_W    = 16,
    parameter logic [7:0]  ACC_INIT = 8'h00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [11:0]      instr,
    input  logic             resume,
    output logic [2:0]       alu_opcode,
    output logic [7:0]       alu_data,
    output logic [7:0]       alu_accum,
    input  logic [7:0]       alu_result,
    output logic [7:0]       accum,
    output logic             zero,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [2:0]       OP_LDA  = 3'b001;
    localparam logic [2:0]       OP_SKZ  = 3'b010;
    localparam logic [2:0]       OP_HLT  = 3'b011;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     next_state;
    logic       skip;
    logic       accept;
    logic       instr_cls;
    logic [2:0] instr_op;
    logic [7:0] instr_imm;

    assign instr_cls = instr[11];
    assign instr_op  = instr[10:8];
    assign instr_imm = instr[7:0];

    // Handshake completes only while idle; ready is purely a function of state.
    assign accept    = instr_valid && (state == IDLE);
    assign alu_accum = accum;
    assign zero      = (accum == 8'h00);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/status outputs; a pending skip swallows the next instruction.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        halted      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (accept && !skip) begin
                    if (!instr_cls) begin
                        next_state = EXEC;
                    end else if (instr_op == OP_HLT) begin
                        next_state = HALT;
                    end
                end
            end
            EXEC: next_state = WB;
            WB:   next_state = IDLE;
            HALT: begin
                halted = 1'b1;
                if (resume) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Accumulator, skip flag, ALU operand registers and retired counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accum      <= ACC_INIT;
            skip       <= 1'b0;
            retired    <= '0;
            alu_opcode <= 3'b000;
            alu_data   <= 8'h00;
        end else begin
            if (accept) begin
                if (skip) begin
                    skip <= 1'b0;
                end else if (!instr_cls) begin
                    // Operands stay stable through EXEC so the ALU captures them at its end.
                    alu_opcode <= instr_op;
                    alu_data   <= instr_imm;
                end else begin
                    if (instr_op == OP_LDA) begin
                        accum <= instr_imm;
                    end
                    if (instr_op == OP_SKZ) begin
                        skip <= zero;
                    end
                    retired <= retired + CNT_ONE;
                end
            end
            if (state == WB) begin
                accum   <= alu_result;
                retired <= retired + CNT_ONE;
            end
        end
    end

endmodule
